// File: rtl/masked_stim_gen_pkg.sv
// masked_stim_gen_pkg: shared types and constants for the masked-gate stimulus generator
// and the correlation test interface that consumes its {r2, r1, b, a} vector.
`default_nettype none

package masked_stim_gen_pkg;

    localparam int LFSR_W = 16;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam int TAP_A = 15;
    localparam int TAP_B = 13;
    localparam int TAP_C = 12;
    localparam int TAP_D = 10;

    localparam int A_BIT  = 0;
    localparam int B_BIT  = 1;
    localparam int R1_BIT = 2;
    localparam int R2_BIT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s);
        return (s == '0) ? 16'h0001 : s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/masked_stim_gen_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR with synchronous load and step; q exposes the low Q_W bits.
`default_nettype none

module lfsr16
    import masked_stim_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VAL = 16'h0001,
    parameter int                Q_W       = LFSR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [Q_W-1:0]    q
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic              fb;

    assign fb = lfsr_q[TAP_A] ^ lfsr_q[TAP_B] ^ lfsr_q[TAP_C] ^ lfsr_q[TAP_D];

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (step) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= RESET_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q[Q_W-1:0];

endmodule

`default_nettype wire

// File: rtl/masked_stim_gen.sv
// masked_stim_gen: seeded LFSR stimulus sequencer issuing N_TRACES vectors, each held for a settle window.
// Optional macro FIXED_VS_RANDOM_EN interleaves FIXED_VEC with random vectors (vec_class marks fixed).
`default_nettype none

module masked_stim_gen
    import masked_stim_gen_pkg::*;
#(
    parameter int                IN_SIZE       = 4,
    parameter int                N_TRACES      = 1024,
    parameter int                SETTLE_CYCLES = 8,
    parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
    parameter int                IDX_W         = 16
`ifdef FIXED_VS_RANDOM_EN
    ,
    parameter logic [IN_SIZE-1:0] FIXED_VEC    = '0
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               cap_ready,
    output logic [IN_SIZE-1:0] in_vec,
    output logic               vec_valid,
    output logic [IDX_W-1:0]   trace_idx,
    output logic               busy,
    output logic               done,
    output logic               vec_class
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
`ifdef FIXED_VS_RANDOM_EN
    localparam int Q_W = LFSR_W;
`else
    localparam int Q_W = IN_SIZE;
`endif
    localparam logic [LFSR_W-1:0] SEED_EFF = fix_seed(SEED);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [IDX_W-1:0]   trace_idx_q, trace_idx_d;
    logic [IN_SIZE-1:0] in_vec_q, in_vec_d;
    logic               vec_valid_q, vec_valid_d;
    logic               lfsr_load;
    logic               lfsr_step;
    logic               issue;
    logic               issue_seed;
    logic [Q_W-1:0]     lfsr_val;

    lfsr16 #(
        .RESET_VAL (SEED_EFF),
        .Q_W       (Q_W)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .seed (SEED_EFF),
        .q    (lfsr_val)
    );

`ifdef FIXED_VS_RANDOM_EN
    logic vec_class_q, vec_class_d;
    logic fixed_sel;
`endif

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        trace_idx_d  = trace_idx_q;
        in_vec_d     = in_vec_q;
        vec_valid_d  = 1'b0;
        lfsr_load    = 1'b0;
        lfsr_step    = 1'b0;
        issue        = 1'b0;
        issue_seed   = 1'b0;
`ifdef FIXED_VS_RANDOM_EN
        vec_class_d  = vec_class_q;
        fixed_sel    = 1'b0;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = APPLY;
                    trace_idx_d = '0;
                    lfsr_load   = 1'b1;
                    issue       = 1'b1;
                    issue_seed  = 1'b1;
                end
            end
            APPLY: begin
                lfsr_step    = 1'b1;
                settle_cnt_d = CNT_W'(SETTLE_CYCLES - 1);
                state_d      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_q != '0) begin
                    settle_cnt_d = settle_cnt_q - CNT_W'(1);
                end else if (cap_ready) begin
                    if (trace_idx_q == IDX_W'(N_TRACES - 1)) begin
                        state_d = DONE;
                    end else begin
                        trace_idx_d = trace_idx_q + IDX_W'(1);
                        state_d     = APPLY;
                        issue       = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The vector is registered on entry to APPLY so vec_valid and in_vec appear together;
        // on a fresh start the LFSR is still being reloaded, so the seed is used directly.
        if (issue) begin
            vec_valid_d = 1'b1;
            in_vec_d    = issue_seed ? SEED_EFF[IN_SIZE-1:0] : lfsr_val[IN_SIZE-1:0];
`ifdef FIXED_VS_RANDOM_EN
            fixed_sel   = issue_seed ? SEED_EFF[LFSR_W-1] : lfsr_val[LFSR_W-1];
            vec_class_d = fixed_sel;
            if (fixed_sel) begin
                in_vec_d = FIXED_VEC;
            end
`endif
        end

        if (abort) begin
            state_d      = IDLE;
            settle_cnt_d = '0;
            in_vec_d     = '0;
            vec_valid_d  = 1'b0;
            lfsr_load    = 1'b0;
            lfsr_step    = 1'b0;
`ifdef FIXED_VS_RANDOM_EN
            vec_class_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            trace_idx_q  <= '0;
            in_vec_q     <= '0;
            vec_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            trace_idx_q  <= trace_idx_d;
            in_vec_q     <= in_vec_d;
            vec_valid_q  <= vec_valid_d;
        end
    end

`ifdef FIXED_VS_RANDOM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_class_q <= 1'b0;
        end else begin
            vec_class_q <= vec_class_d;
        end
    end
    assign vec_class = vec_class_q;
`else
    assign vec_class = 1'b0;
`endif

    assign in_vec    = in_vec_q;
    assign vec_valid = vec_valid_q;
    assign trace_idx = trace_idx_q;
    assign busy      = (state_q == APPLY) || (state_q == SETTLE);
    assign done      = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_masked_stim_gen.sv
// tb_masked_stim_gen: table-driven and randomized checks of masked_stim_gen against a spec-level model.
`default_nettype none

module tb_masked_stim_gen;

    localparam int          S    = 2;
    localparam int          NT   = 3;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [3:0]  FIX  = 4'hA;

    logic        clk = 1'b0;
    logic        rst, start, abort, cap_ready;
    logic [3:0]  in_vec;
    logic        vec_valid, busy, done, vec_class;
    logic [15:0] trace_idx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    masked_stim_gen #(
        .IN_SIZE       (4),
        .N_TRACES      (NT),
        .SETTLE_CYCLES (S),
        .SEED          (SEED),
        .IDX_W         (16)
`ifdef FIXED_VS_RANDOM_EN
        ,
        .FIXED_VEC     (FIX)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cap_ready (cap_ready),
        .in_vec    (in_vec),
        .vec_valid (vec_valid),
        .trace_idx (trace_idx),
        .busy      (busy),
        .done      (done),
        .vec_class (vec_class)
    );

`ifdef FIXED_VS_RANDOM_EN
    logic        start2;
    logic [3:0]  in_vec2;
    logic        vec_valid2, busy2, done2, vec_class2;
    logic [15:0] trace_idx2;

    masked_stim_gen #(
        .IN_SIZE       (4),
        .N_TRACES      (1000),
        .SETTLE_CYCLES (1),
        .SEED          (SEED),
        .IDX_W         (16),
        .FIXED_VEC     (FIX)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .abort     (1'b0),
        .cap_ready (1'b1),
        .in_vec    (in_vec2),
        .vec_valid (vec_valid2),
        .trace_idx (trace_idx2),
        .busy      (busy2),
        .done      (done2),
        .vec_class (vec_class2)
    );
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // LFSR contents while vector n of a campaign is being issued.
    function automatic logic [15:0] model_word(input int n);
        logic [15:0] x;
        x = SEED;
        for (int i = 0; i < n; i++) x = lfsr_adv(x);
        return x;
    endfunction

    function automatic logic [3:0] model_vec(input int n);
        logic [15:0] x;
        x = model_word(n);
`ifdef FIXED_VS_RANDOM_EN
        if (x[15]) return FIX;
`endif
        return x[3:0];
    endfunction

    function automatic logic model_cls(input int n);
`ifdef FIXED_VS_RANDOM_EN
        logic [15:0] x;
        x = model_word(n);
        return x[15];
`else
        return (n < 0);
`endif
    endfunction

    typedef struct {
        logic        st;
        logic        cp;
        logic        vv;
        int          vn;
        logic [15:0] idx;
        logic        bsy;
        logic        dn;
    } row_t;

    row_t tbl[14];

    task automatic set_row(input int k, input logic st, input logic vv, input int vn,
                           input logic [15:0] idx, input logic bsy, input logic dn);
        tbl[k].st  = st;
        tbl[k].cp  = 1'b1;
        tbl[k].vv  = vv;
        tbl[k].vn  = vn;
        tbl[k].idx = idx;
        tbl[k].bsy = bsy;
        tbl[k].dn  = dn;
    endtask

    task automatic check_outs(input string tag, input logic vv, input int vn,
                              input logic [15:0] idx, input logic bsy, input logic dn);
        chk({tag, "_vec_valid"}, 32'(vec_valid), 32'(vv));
        chk({tag, "_in_vec"},    32'(in_vec),    32'(model_vec(vn)));
        chk({tag, "_trace_idx"}, 32'(trace_idx), 32'(idx));
        chk({tag, "_busy"},      32'(busy),      32'(bsy));
        chk({tag, "_done"},      32'(done),      32'(dn));
        chk({tag, "_vec_class"}, 32'(vec_class), 32'(model_cls(vn)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t_last, n, cyc;
        logic        finished, exit_now;
        logic [3:0]  held;

        rst = 1'b1; start = 1'b0; abort = 1'b0; cap_ready = 1'b1;
`ifdef FIXED_VS_RANDOM_EN
        start2 = 1'b0;
`endif
        #2;
        chk("reset_in_vec",    32'(in_vec),    32'h0);
        chk("reset_vec_valid", 32'(vec_valid), 32'h0);
        chk("reset_trace_idx", 32'(trace_idx), 32'h0);
        chk("reset_busy",      32'(busy),      32'h0);
        chk("reset_done",      32'(done),      32'h0);
        chk("reset_vec_class", 32'(vec_class), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Rows: inputs for one cycle, then the state visible after the edge.
        set_row(0,  1'b1, 1'b1, 0, 16'd0, 1'b1, 1'b0);
        set_row(1,  1'b0, 1'b0, 0, 16'd0, 1'b1, 1'b0);
        set_row(2,  1'b0, 1'b0, 0, 16'd0, 1'b1, 1'b0);
        set_row(3,  1'b0, 1'b1, 1, 16'd1, 1'b1, 1'b0);
        set_row(4,  1'b0, 1'b0, 1, 16'd1, 1'b1, 1'b0);
        set_row(5,  1'b0, 1'b0, 1, 16'd1, 1'b1, 1'b0);
        set_row(6,  1'b0, 1'b1, 2, 16'd2, 1'b1, 1'b0);
        set_row(7,  1'b0, 1'b0, 2, 16'd2, 1'b1, 1'b0);
        set_row(8,  1'b0, 1'b0, 2, 16'd2, 1'b1, 1'b0);
        set_row(9,  1'b0, 1'b0, 2, 16'd2, 1'b0, 1'b1);
        set_row(10, 1'b1, 1'b1, 0, 16'd0, 1'b1, 1'b0);
        set_row(11, 1'b1, 1'b0, 0, 16'd0, 1'b1, 1'b0);
        set_row(12, 1'b1, 1'b0, 0, 16'd0, 1'b1, 1'b0);
        set_row(13, 1'b0, 1'b1, 1, 16'd1, 1'b1, 1'b0);

        for (int k = 0; k < 14; k++) begin
            start     = tbl[k].st;
            cap_ready = tbl[k].cp;
            tick();
            check_outs($sformatf("tbl%0d", k), tbl[k].vv, tbl[k].vn, tbl[k].idx, tbl[k].bsy, tbl[k].dn);
        end
        start = 1'b0;

        // Let the campaign finish before the randomized runs.
        for (int i = 0; i < 20 && !done; i++) tick();
        chk("tbl_final_done", 32'(done), 32'h1);

        // Randomized cap_ready; a vector leaves SETTLE on the first cycle at or beyond
        // APPLY+SETTLE_CYCLES in which cap_ready is high.
        for (int camp = 0; camp < 6; camp++) begin
            cap_ready = 1'b1;
            start     = 1'b1;
            tick();
            start     = 1'b0;
            chk("rnd_first_valid", 32'(vec_valid), 32'h1);
            chk("rnd_first_vec",   32'(in_vec),    32'(model_vec(0)));
            t_last   = 0;
            n        = 1;
            held     = model_vec(0);
            finished = 1'b0;
            cyc      = 0;
            while (cyc < 300 && !finished) begin
                cap_ready = ($urandom_range(0, 3) != 0);
                exit_now  = (cyc >= t_last + S) && cap_ready;
                tick();
                if (exit_now && n < NT) begin
                    chk("rnd_valid", 32'(vec_valid), 32'h1);
                    chk("rnd_vec",   32'(in_vec),    32'(model_vec(n)));
                    chk("rnd_idx",   32'(trace_idx), 32'(n));
                    chk("rnd_class", 32'(vec_class), 32'(model_cls(n)));
                    held   = model_vec(n);
                    t_last = cyc + 1;
                    n++;
                end else if (exit_now) begin
                    chk("rnd_done",       32'(done),      32'h1);
                    chk("rnd_done_valid", 32'(vec_valid), 32'h0);
                    chk("rnd_done_vec",   32'(in_vec),    32'(held));
                    finished = 1'b1;
                end else begin
                    chk("rnd_hold_valid", 32'(vec_valid), 32'h0);
                    chk("rnd_hold_vec",   32'(in_vec),    32'(held));
                    chk("rnd_hold_busy",  32'(busy),      32'h1);
                end
                cyc++;
            end
            chk("rnd_finished", 32'(finished), 32'h1);
        end

        // Stall at count 0 with cap_ready low, then release.
        cap_ready = 1'b0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk("stall_first_valid", 32'(vec_valid), 32'h1);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("stall_valid", 32'(vec_valid), 32'h0);
            chk("stall_vec",   32'(in_vec),    32'(model_vec(0)));
            chk("stall_idx",   32'(trace_idx), 32'h0);
        end
        cap_ready = 1'b1;
        tick();
        chk("stall_release_valid", 32'(vec_valid), 32'h1);
        chk("stall_release_vec",   32'(in_vec),    32'(model_vec(1)));
        chk("stall_release_idx",   32'(trace_idx), 32'h1);

        // Abort coinciding with a SETTLE exit.
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_vec",    32'(in_vec),    32'h0);
        chk("abort_vec_valid", 32'(vec_valid), 32'h0);
        chk("abort_busy",      32'(busy),      32'h0);
        chk("abort_done",      32'(done),      32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_quiet_valid", 32'(vec_valid), 32'h0);
            chk("abort_quiet_busy",  32'(busy),      32'h0);
        end

        // Asynchronous reset in the middle of the second vector's SETTLE.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("prereset_idx", 32'(trace_idx), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("areset_in_vec",    32'(in_vec),    32'h0);
        chk("areset_vec_valid", 32'(vec_valid), 32'h0);
        chk("areset_trace_idx", 32'(trace_idx), 32'h0);
        chk("areset_busy",      32'(busy),      32'h0);
        chk("areset_done",      32'(done),      32'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postreset_valid", 32'(vec_valid), 32'h0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_valid", 32'(vec_valid), 32'h1);
        chk("restart_vec",   32'(in_vec),    32'(model_vec(0)));
        chk("restart_idx",   32'(trace_idx), 32'h0);

`ifdef FIXED_VS_RANDOM_EN
        begin
            int          pulses, nfixed;
            logic [15:0] x;
            pulses = 0;
            nfixed = 0;
            x      = SEED;
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            for (int i = 0; i < 2600 && !done2; i++) begin
                if (vec_valid2) begin
                    chk("fvr_class", 32'(vec_class2), 32'(x[15]));
                    chk("fvr_vec",   32'(in_vec2),    32'(x[15] ? FIX : x[3:0]));
                    if (vec_class2) nfixed++;
                    pulses++;
                    x = lfsr_adv(x);
                end
                tick();
            end
            chk("fvr_pulses", 32'(pulses), 32'd1000);
            chk("fvr_split",  32'((nfixed >= 450) && (nfixed <= 550)), 32'h1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
